// File: rtl/morse_symbol_assembler_if.sv
// Character output channel of the Morse symbol assembler.
// The master drives the valid/len/bits/err fields and the slave answers with ready.
// The fields carry the registered code word handed to the downstream character lookup.
interface morse_symbol_assembler_if #(
  parameter int MAX_LEN = 5
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic             out_valid;
  logic             out_ready;
  logic [LEN_W-1:0] out_len;
  logic [MAX_LEN-1:0] out_bits;
  logic             out_err;

  modport master (
    output out_valid,
    output out_len,
    output out_bits,
    output out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_len,
    input  out_bits,
    input  out_err,
    output out_ready
  );
endinterface

// File: rtl/morse_symbol_assembler.sv
// Collects dot/dash symbols into a code word and closes it on a letter gap.
// Latency: out_valid rises one cycle after the end event (pulse or key-timer gap).
// Backpressure: the output register holds while !out_ready; a character closing onto a held one is dropped.
module morse_symbol_assembler #(
  parameter int MAX_LEN = 5,
  parameter int CNT_W   = 8,
  parameter int DASH_TH = 3,
  parameter int GAP_TH  = 3,
  parameter int MODE    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  input  logic key,
  input  logic dot,
  input  logic dash,
  input  logic end_char,
  morse_symbol_assembler_if.master chr,
  output logic drop,
  output logic busy
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_C  = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_TH);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, COLLECT, ERR} state_t;

  state_t             state, state_nxt, upd_state;
  logic [LEN_W-1:0]   len, len_nxt, upd_len;
  logic [MAX_LEN-1:0] bits, bits_nxt, upd_bits;
  logic               upd_err;
  logic               close;

  // Key timer state (only drives events when MODE == 1)
  logic [CNT_W-1:0] down_cnt, up_cnt, up_inc;
  logic             key_q, gap_fired;
  logic             t_release, t_dot, t_dash, t_end;

  logic ev_dot, ev_dash, ev_end;

  assign up_inc    = (up_cnt == CNT_MAX) ? up_cnt : up_cnt + 1'b1;
  assign t_release = tick_en && !key && key_q;
  assign t_dash    = t_release && (down_cnt >= DASH_C);
  assign t_dot     = t_release && (down_cnt < DASH_C);
  // The gap fires once per key-up run, and only if something is being collected
  // (a symbol released on this same tick counts).
  assign t_end     = tick_en && !key && !gap_fired && (up_inc == GAP_C) &&
                     ((len != '0) || (state == ERR) || t_release);

  assign ev_dot  = (MODE == 1) ? t_dot  : dot;
  assign ev_dash = (MODE == 1) ? t_dash : dash;
  assign ev_end  = (MODE == 1) ? t_end  : end_char;

  assign busy = (len != '0) || (state == ERR);

  // Key timer: press/release durations sampled on tick_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_cnt  <= '0;
      up_cnt    <= '0;
      key_q     <= 1'b0;
      gap_fired <= 1'b0;
    end else if (tick_en) begin
      key_q <= key;
      if (key) begin
        down_cnt  <= (down_cnt == CNT_MAX) ? down_cnt : down_cnt + 1'b1;
        up_cnt    <= '0;
        gap_fired <= 1'b0;
      end else begin
        up_cnt <= up_inc;
        if (key_q) begin
          down_cnt <= '0;
        end
        if (t_end) begin
          gap_fired <= 1'b1;
        end
      end
    end
  end

  // Collector next state: apply the symbol first, then close on end
  always_comb begin
    upd_state = state;
    upd_len   = len;
    upd_bits  = bits;
    if (ev_dot && ev_dash) begin
      upd_state = ERR;
    end else if (ev_dot || ev_dash) begin
      if (state != ERR) begin
        if (len < MAX_C) begin
          upd_bits  = bits | (MAX_LEN'(ev_dash) << len);
          upd_len   = len + 1'b1;
          upd_state = COLLECT;
        end else begin
          upd_state = ERR;
        end
      end
    end
    upd_err = (upd_state == ERR);
    // An end in IDLE with no symbol has nothing to close
    close = ev_end && (upd_state != IDLE);
    state_nxt = close ? IDLE : upd_state;
    len_nxt   = close ? '0   : upd_len;
    bits_nxt  = close ? '0   : upd_bits;
  end

  // Collector state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      bits  <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      bits  <= bits_nxt;
    end
  end

  // Output register: load on close when free or draining, else drop the newcomer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chr.out_valid <= 1'b0;
      chr.out_len   <= '0;
      chr.out_bits  <= '0;
      chr.out_err   <= 1'b0;
      drop          <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (close) begin
        if (!chr.out_valid || chr.out_ready) begin
          chr.out_valid <= 1'b1;
          chr.out_len   <= upd_len;
          chr.out_bits  <= upd_bits;
          chr.out_err   <= upd_err;
        end else begin
          drop <= 1'b1;
        end
      end else if (chr.out_valid && chr.out_ready) begin
        chr.out_valid <= 1'b0;
        chr.out_len   <= '0;
        chr.out_bits  <= '0;
        chr.out_err   <= 1'b0;
      end
    end
  end
endmodule

// File: doc/morse_symbol_assembler.md
Name: morse_symbol_assembler

Overview:
- Sequential, parametrised successor to the combinational dot/dash next-state tables of the Morse decoder.
- Accumulates dot/dash symbols into a registered code word and closes it on a letter gap. It presents `{length, bits, error}` to the downstream character lookup through a valid/ready output register.
- MODE 0 takes pre-classified dot/dash/end pulses. MODE 1 times a raw key line itself on a sample strobe.

Parameters:
- MAX_LEN, 5: maximum symbols per character; longer sequences flag an error.
- CNT_W, 8: width of the key-down and key-up duration counters (MODE 1).
- DASH_TH, 3: key-down ticks ≥ DASH_TH classify as dash; 1..DASH_TH-1 as dot.
- GAP_TH, 3: consecutive key-up ticks that end a character.
- MODE, 0: 0 = pulse inputs, 1 = raw key timing.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- tick_en, in, 1: MODE 1 sample strobe; key is evaluated only when high.
- key, in, 1: MODE 1 raw key line, 1 = pressed.
- dot, in, 1: MODE 0 one-cycle dot pulse.
- dash, in, 1: MODE 0 one-cycle dash pulse.
- end_char, in, 1: MODE 0 one-cycle letter-gap pulse.
- out_valid, out, 1: character available.
- out_ready, in, 1: consumer accepts.
- out_len, out, $clog2(MAX_LEN+1): symbol count.
- out_bits, out, MAX_LEN: bit i = symbol i (first received at bit 0); 1 = dash; bits ≥ out_len are 0.
- out_err, out, 1: character overflowed, or a dot and dash arrived together.
- drop, out, 1: one-cycle pulse when a completed character is discarded.
- busy, out, 1: a character is being collected (len > 0 or ERR state).

Behaviour:
- Reset state: rst high asynchronously clears every register immediately, including mid-character and a held output. All outputs go to 0, FSM goes to IDLE, and both counters go to 0.
- Symbol/end events: MODE 0 uses dot, dash and end_char directly. In MODE 1 those three inputs are ignored and events come from the key timer.
- FSM states: IDLE, COLLECT, ERR.
- IDLE:
  - dot or dash → append at bit 0, len = 1, go to COLLECT.
  - end_char is ignored; no empty characters are produced.
- COLLECT:
  - A symbol with len < MAX_LEN appends at bit[len] and increments len.
  - A symbol with len == MAX_LEN → ERR; bits and len are frozen.
- Simultaneous dot and dash in one cycle: treated as an error symbol → ERR from IDLE or COLLECT.
- ERR: symbols are ignored; end_char closes the character with err = 1.
- Symbol and end_char in the same cycle: the symbol is applied first, then the character closes with the updated len/bits/err. If that symbol overflows, err = 1.
- Character close:
  - Registered outputs update on the next edge; out_valid rises one cycle after the end event.
  - The collector returns to IDLE with len = 0 and bits = 0 in that same cycle.
- Output register:
  - Fields are held stable while out_valid && !out_ready.
  - A transfer occurs on out_valid && out_ready.
  - If a new character closes while the register holds an untransferred character and out_ready is low, the new one is discarded and drop pulses. The held character is unchanged.
  - If out_ready is high in that same cycle, the register loads the new character and out_valid stays high; there is no drop.
- MODE 1 key timer, evaluated only on tick_en:
  - key = 1: the down-counter increments (saturating at 2^CNT_W−1); the up-counter clears.
  - key 1→0 transition: emit a dash if down ≥ DASH_TH, otherwise a dot; the down-counter clears.
  - key = 0: the up-counter increments (saturating). When it first equals GAP_TH and len > 0 or state is ERR, emit one end event. It does not re-fire until the key is pressed again.
  - Events are generated internally on the tick_en cycle and follow MODE 0 timing from there.

Test Plan:
- MODE 0: dot, dash, dash, then end_char → out_valid one cycle later with out_len = 3, out_bits = 00110, out_err = 0. The fields hold for 4 cycles with out_ready = 0, then clear after a ready handshake.
- MODE 0: 6 dashes, then end_char → out_len = 5, out_bits = 11111, out_err = 1. The sixth dash is not stored.
- MODE 0: dot and dash high in the same cycle, then end_char → out_err = 1, out_len = 0. end_char in IDLE produces nothing.
- Back-pressure: with out_ready = 0, close "dot" then "dash" → drop pulses once and the output still shows len = 1, bits = 00000. Repeating with out_ready = 1 on the second close instead loads len = 1, bits = 00001 with no drop.
- MODE 1 (DASH_TH = 3, GAP_TH = 3), tick_en every cycle: key high 1 tick, low 1, high 4, low 3 → out_len = 2, out_bits = 00010. Staying low a further 10 ticks produces no second character.
- Reset mid-collection: after 2 symbols and with a held output, assert rst for 1 cycle → all outputs are 0 immediately. Then dot, end_char → out_len = 1, bits = 00000.
